// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - received-byte valid/ready handshake between uart_rx_fifo and its consumer
`timescale 1ns/1ps
interface uart_rx_fifo_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a show-ahead byte FIFO
// Optional even-parity (8E1) framing is built when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            rxd_i,
   uart_rx_fifo_if.master                  rx_if,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
   output logic                            busy_o,
   output logic                            frame_err_o,
   output logic                            overrun_o,
   output logic                            parity_err_o
);

   localparam int DIV = CLK_HZ / (BAUD * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   logic [DW-1:0] div_q;
   logic          tick;
   logic          rxd_meta_q;
   logic          rxd_s_q;
   state_t        state_q;
   logic [3:0]    phase_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shift_q;
   logic          frame_err_q;
   logic          overrun_q;
   logic          stop_hit;
   logic          push;
   logic          pop;
   logic          full;
   logic          wr_en;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tick = (div_q == DW'(DIV - 1));

   // Free-running 16x oversampling tick; frames align to it through the phase counter
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd_i;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   assign stop_hit = (state_q == S_STOP) && tick && (phase_q == 4'd15);

`ifdef UART_RX_PARITY_EN
   logic par_q;
   logic parity_err_q;
   logic par_bad;

   // Even parity: data bits plus parity bit must hold an even number of ones
   assign par_bad      = ^{shift_q, par_q};
   assign push         = stop_hit && rxd_s_q && !par_bad;
   assign parity_err_o = parity_err_q;
`else
   assign push         = stop_hit && rxd_s_q;
   assign parity_err_o = 1'b0;
`endif

   // Frame FSM: start-bit midpoint qualification, 16-tick bit sampling, stop check
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               phase_q  <= '0;
               bitcnt_q <= '0;
               if (!rxd_s_q) begin
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (tick) begin
                  if (phase_q == 4'd7) begin
                     phase_q <= '0;
                     state_q <= rxd_s_q ? S_IDLE : S_DATA;
                  end else begin
                     phase_q <= phase_q + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  phase_q <= phase_q + 4'd1;
                  if (phase_q == 4'd15) begin
                     shift_q  <= {rxd_s_q, shift_q[7:1]};
                     bitcnt_q <= bitcnt_q + 3'd1;
                     if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  phase_q <= phase_q + 4'd1;
                  if (phase_q == 4'd15) begin
                     par_q   <= rxd_s_q;
                     state_q <= S_STOP;
                  end
               end
            end
`endif
            S_STOP: begin
               if (tick) begin
                  phase_q <= phase_q + 4'd1;
                  if (phase_q == 4'd15) begin
                     if (!rxd_s_q) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
                     end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            S_BREAK: begin
               if (rxd_s_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pop   = (count_q != '0) && rx_if.rx_ready;
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign wr_en = push && (!full || pop);

   // Occupancy next-state; simultaneous push and pop leave the count unchanged
   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Show-ahead FIFO storage and pointers; a push into a full FIFO without a pop is dropped
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q   <= count_d;
         overrun_q <= push && full && !pop;
      end
   end

   assign rx_if.rx_data  = mem_q[rd_ptr_q];
   assign rx_if.rx_valid = (count_q != '0);
   assign fifo_count_o   = count_q;
   assign busy_o         = (state_q != S_IDLE);
   assign frame_err_o    = frame_err_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 1_000_000;
   localparam int DEPTH  = 8;
   localparam int DIV    = CLK_HZ / (BAUD * 16);
   localparam int BIT    = 16 * DIV;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rxd   = 1'b1;
   logic [3:0] fifo_count;
   logic       busy, frame_err, overrun, parity_err;

   uart_rx_fifo_if rx_if ();

   uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .rxd_i       (rxd),
      .rx_if       (rx_if),
      .fifo_count_o(fifo_count),
      .busy_o      (busy),
      .frame_err_o (frame_err),
      .overrun_o   (overrun),
      .parity_err_o(parity_err)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ferr, n_ovr, n_perr, n_vcyc, n_bcyc;
   logic [7:0] got_q [$];
   logic       rand_en   = 1'b0;
   logic       ready_cmd = 1'b0;
`ifdef UART_RX_PARITY_EN
   logic       par_flip_v = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         low_bits;
      int         exp_bytes;
      int         exp_ferr;
   } vec_t;
   vec_t vecs [5];

   // Consumer side: records every accepted byte and counts pulse outputs
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
         if (frame_err)      n_ferr++;
         if (overrun)        n_ovr++;
         if (parity_err)     n_perr++;
         if (rx_if.rx_valid) n_vcyc++;
         if (busy)           n_bcyc++;
      end
   end

   // Ready driver, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      rx_if.rx_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_cmd;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      got_q.delete();
      n_ferr = 0; n_ovr = 0; n_perr = 0; n_vcyc = 0; n_bcyc = 0;
   endtask

   task automatic bit_time(input logic v);
      rxd = v;
      repeat (BIT) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_time((^d) ^ par_flip_v);
`endif
      bit_time(stop_v);
   endtask

   int         lat;
   int         m_ovr;
   int         exp_ferr;
   logic [7:0] model_q [$];
   logic [7:0] d;
   logic       bad;

   initial begin
      vecs[0] = '{8'h55, 1'b1, 0, 1, 0};
      vecs[1] = '{8'hA3, 1'b0, 1, 0, 1};
      vecs[2] = '{8'h3C, 1'b1, 0, 1, 0};
      vecs[3] = '{8'h00, 1'b1, 0, 1, 0};
      vecs[4] = '{8'hFF, 1'b0, 3, 0, 1};

      // Reset state
      clear_stats();
      repeat (4) @(posedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_valid", int'(rx_if.rx_valid), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_data", int'(rx_if.rx_data), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_ovr", int'(overrun), 0);
      check("rst_perr", int'(parity_err), 0);

      // Push latency: rx_valid rises the cycle after the stop-bit sample tick
      clear_stats();
      @(posedge clk);
      fork
         send_frame(8'h5A, 1'b1);
         begin
            lat = 0;
            while (!rx_if.rx_valid && lat < 20 * BIT) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("lat_min", int'(lat >= 9 * BIT + 7 * DIV + 5), 1);
      check("lat_max", int'(lat <= 9 * BIT + 8 * DIV + 4), 1);
      @(negedge clk);
      check("lat_data", int'(rx_if.rx_data), 'h5A);
      check("lat_count", int'(fifo_count), 1);
      ready_cmd = 1'b1;
      bit_time(1'b1);
      check("lat_popped", got_q.size(), 1);
      check("lat_pop_data", int'(got_q[0]), 'h5A);
      check("lat_count_after", int'(fifo_count), 0);

      // Table-driven single frames with good and broken stop bits
      for (int v = 0; v < 5; v++) begin
         clear_stats();
         send_frame(vecs[v].data, vecs[v].stop);
         repeat (vecs[v].low_bits) bit_time(1'b0);
         bit_time(1'b1);
         bit_time(1'b1);
         @(negedge clk);
         check($sformatf("vec%0d_bytes", v), got_q.size(), vecs[v].exp_bytes);
         if (vecs[v].exp_bytes > 0) check($sformatf("vec%0d_data", v), int'(got_q[0]), int'(vecs[v].data));
         check($sformatf("vec%0d_ferr", v), n_ferr, vecs[v].exp_ferr);
         check($sformatf("vec%0d_vcyc", v), n_vcyc, vecs[v].exp_bytes);
         check($sformatf("vec%0d_ovr", v), n_ovr, 0);
         check($sformatf("vec%0d_busy", v), int'(busy), 0);
      end

      // Short low glitch on an idle line
      clear_stats();
      rxd = 1'b0;
      repeat (4 * DIV) @(posedge clk);
      rxd = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      @(negedge clk);
      check("glitch_bytes", got_q.size(), 0);
      check("glitch_ferr", n_ferr, 0);
      check("glitch_busy_min", int'(n_bcyc >= 7 * DIV + 1), 1);
      check("glitch_busy_max", int'(n_bcyc <= 8 * DIV), 1);
      check("glitch_busy_end", int'(busy), 0);

      // Overrun: nine back-to-back bytes into an eight-entry FIFO with no consumer
      ready_cmd = 1'b0;
      repeat (3) @(posedge clk);
      clear_stats();
      model_q.delete();
      m_ovr = 0;
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 1'b1);
         if (model_q.size() < DEPTH) model_q.push_back(8'(i));
         else m_ovr++;
      end
      bit_time(1'b1);
      @(negedge clk);
      check("ovr_count", int'(fifo_count), model_q.size());
      check("ovr_pulses", n_ovr, m_ovr);
      check("ovr_head", int'(rx_if.rx_data), int'(model_q[0]));
      check("ovr_valid", int'(rx_if.rx_valid), 1);
      ready_cmd = 1'b1;
      repeat (DEPTH + 4) @(posedge clk);
      @(negedge clk);
      check("drain_size", got_q.size(), model_q.size());
      for (int i = 0; i < model_q.size(); i++)
         check($sformatf("drain_%0d", i), int'(got_q[i]), int'(model_q[i]));
      check("drain_count", int'(fifo_count), 0);

      // Reset in the middle of a data bit of 0xFF
      clear_stats();
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b1);
      repeat (BIT / 2) @(posedge clk);
      reset = 1'b1;
      rxd   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst_busy", int'(busy), 0);
      check("midrst_valid", int'(rx_if.rx_valid), 0);
      @(posedge clk);
      reset = 1'b0;
      repeat (8) bit_time(1'b1);
      send_frame(8'h81, 1'b1);
      bit_time(1'b1);
      @(negedge clk);
      check("midrst_bytes", got_q.size(), 1);
      check("midrst_data", int'(got_q[0]), 'h81);
      check("midrst_ferr", n_ferr, 0);
      check("midrst_ovr", n_ovr, 0);

`ifdef UART_RX_PARITY_EN
      // Even parity: correct parity accepted, flipped parity rejected with a pulse
      clear_stats();
      par_flip_v = 1'b0;
      send_frame(8'h07, 1'b1);
      par_flip_v = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip_v = 1'b0;
      bit_time(1'b1);
      @(negedge clk);
      check("par_bytes", got_q.size(), 1);
      check("par_data", int'(got_q[0]), 'h07);
      check("par_perr", n_perr, 1);
      check("par_ferr", n_ferr, 0);
`endif

      // Random frames with random back-pressure against a queue model
      clear_stats();
      model_q.delete();
      exp_ferr = 0;
      rand_en  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         d   = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         send_frame(d, !bad);
         if (bad) begin
            exp_ferr++;
            bit_time(1'b0);
            bit_time(1'b1);
         end else begin
            model_q.push_back(d);
            repeat ($urandom_range(0, 2)) bit_time(1'b1);
         end
      end
      bit_time(1'b1);
      rand_en   = 1'b0;
      ready_cmd = 1'b1;
      repeat (2 * DEPTH) @(posedge clk);
      @(negedge clk);
      check("rand_size", got_q.size(), model_q.size());
      for (int i = 0; i < model_q.size() && i < got_q.size(); i++)
         check($sformatf("rand_%0d", i), int'(got_q[i]), int'(model_q[i]));
      check("rand_ferr", n_ferr, exp_ferr);
      check("rand_ovr", n_ovr, 0);
      check("rand_perr", n_perr, 0);
      check("rand_count", int'(fifo_count), 0);
      check("rand_busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
